// File: rtl/npu_pkg.sv
// Shared definitions for the NPU cube MAC lane: Booth code field layout,
// sequencer states and the radix-4 digit encoder helper.
package npu_pkg;

    localparam int DWB_PER_CODE = 3;
    localparam int CODE_X1      = 0;
    localparam int CODE_X2      = 1;
    localparam int CODE_NEG     = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_e;

    // Triplet {w[2i+1], w[2i], w[2i-1]} -> {neg, x2, x1}; -0 maps to plain zero
    function automatic logic [DWB_PER_CODE-1:0] booth_digit(input logic [2:0] trip);
        logic [DWB_PER_CODE-1:0] code;
        code = {DWB_PER_CODE{1'b0}};
        case (trip)
            3'b001, 3'b010: code[CODE_X1] = 1'b1;
            3'b011:         code[CODE_X2] = 1'b1;
            3'b100: begin
                code[CODE_NEG] = 1'b1;
                code[CODE_X2]  = 1'b1;
            end
            3'b101, 3'b110: begin
                code[CODE_NEG] = 1'b1;
                code[CODE_X1]  = 1'b1;
            end
            default:        code = {DWB_PER_CODE{1'b0}};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/npu_booth_enc.sv
// Combinational radix-4 Booth encoder: signed weight -> per-line code and
// the +1 correction bits the generator needs for its negated lines.
module npu_booth_enc
    import npu_pkg::*;
#(
    parameter int DWB      = 8,
    parameter int DWB_CODE = DWB / 2 * DWB_PER_CODE
) (
    input  logic [DWB-1:0]      i_weight,
    output logic [DWB_CODE-1:0] o_code,
    output logic [DWB/2-1:0]    o_corr
);

    logic [DWB:0]              w_ext;
    logic [DWB_PER_CODE-1:0]   w_digit;

    assign w_ext = {i_weight, 1'b0};

    // One Booth digit per line, overlapping triplets with an implicit w[-1]=0
    always_comb begin
        o_code  = {DWB_CODE{1'b0}};
        o_corr  = {(DWB/2){1'b0}};
        w_digit = {DWB_PER_CODE{1'b0}};
        for (int i = 0; i < DWB / 2; i++) begin
            w_digit = booth_digit(w_ext[2*i +: 3]);
            o_code[DWB_PER_CODE*i +: DWB_PER_CODE] = w_digit;
            o_corr[i] = w_digit[CODE_NEG];
        end
    end

endmodule

// File: rtl/npu_booth_code_seq.sv
// Booth code sequencer for one NPU cube MAC lane: latches an encoded weight and
// streams a configured burst of activations to the partial-product generator.
module npu_booth_code_seq
    import npu_pkg::*;
#(
    parameter int DWA      = 8,
    parameter int DWB      = 8,
    parameter int LEN_W    = 8,
    parameter int DWB_CODE = DWB / 2 * DWB_PER_CODE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                cfg_is_signed,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DWB-1:0]      w_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [DWA-1:0]      a_data,
    output logic [DWA-1:0]      add_tree_data,
    output logic [DWB_CODE-1:0] add_tree_para_code,
    output logic                is_signed,
    output logic [DWB/2-1:0]    pp_corr,
    output logic                pp_valid,
    input  logic                pp_ready,
    output logic                pp_last,
    output logic                busy,
    output logic                done
);

    seq_state_e          r_state;
    logic [LEN_W-1:0]    r_cnt;
    logic [DWA-1:0]      r_data;
    logic [DWB_CODE-1:0] r_code;
    logic [DWB/2-1:0]    r_corr;
    logic                r_is_signed;
    logic                r_pp_valid;
    logic                r_pp_last;
    logic                r_done;

    logic [DWB_CODE-1:0] w_enc_code;
    logic [DWB/2-1:0]    w_enc_corr;
    logic                w_w_ready;
    logic                w_a_ready;
    logic                w_w_hs;
    logic                w_a_hs;
    logic                w_pp_hs;
    logic                w_cnt_zero;

    npu_booth_enc #(
        .DWB      (DWB),
        .DWB_CODE (DWB_CODE)
    ) u_enc (
        .i_weight (w_data),
        .o_code   (w_enc_code),
        .o_corr   (w_enc_corr)
    );

    assign w_w_hs     = w_valid && w_w_ready;
    assign w_a_hs     = a_valid && w_a_ready;
    assign w_pp_hs    = r_pp_valid && pp_ready;
    assign w_cnt_zero = (r_cnt == {LEN_W{1'b0}});

    // Ready generation: weight only while idle and drained, beats only into a free output slot
    always_comb begin
        w_w_ready = 1'b0;
        w_a_ready = 1'b0;
        case (r_state)
            IDLE:    w_w_ready = !r_pp_valid;
            STREAM:  w_a_ready = !r_pp_valid || pp_ready;
            default: begin
                w_w_ready = 1'b0;
                w_a_ready = 1'b0;
            end
        endcase
    end

    // FSM and remaining-beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= {LEN_W{1'b0}};
        end else if (clr) begin
            r_state <= IDLE;
            r_cnt   <= {LEN_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_w_hs) begin
                        r_state <= STREAM;
                        r_cnt   <= cfg_len;
                    end
                end
                STREAM: begin
                    if (w_a_hs) begin
                        if (w_cnt_zero) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= {LEN_W{1'b0}};
                end
            endcase
        end
    end

    // Weight-side registers; clr deliberately leaves the last code in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code      <= {DWB_CODE{1'b0}};
            r_corr      <= {(DWB/2){1'b0}};
            r_is_signed <= 1'b0;
        end else if (!clr && w_w_hs) begin
            r_code      <= w_enc_code;
            r_corr      <= w_enc_corr;
            r_is_signed <= cfg_is_signed;
        end
    end

    // Single-entry output register toward the adder tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= {DWA{1'b0}};
            r_pp_valid <= 1'b0;
            r_pp_last  <= 1'b0;
        end else if (clr) begin
            r_pp_valid <= 1'b0;
            r_pp_last  <= 1'b0;
        end else if (w_a_hs) begin
            r_data     <= a_data;
            r_pp_valid <= 1'b1;
            r_pp_last  <= w_cnt_zero;
        end else if (pp_ready) begin
            r_pp_valid <= 1'b0;
            r_pp_last  <= 1'b0;
        end
    end

    // Burst completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (clr) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_pp_hs && r_pp_last;
        end
    end

    assign w_ready            = w_w_ready;
    assign a_ready            = w_a_ready;
    assign add_tree_data      = r_data;
    assign add_tree_para_code = r_code;
    assign is_signed          = r_is_signed;
    assign pp_corr            = r_corr;
    assign pp_valid           = r_pp_valid;
    assign pp_last            = r_pp_last;
    assign done               = r_done;
    assign busy               = (r_state != IDLE) || r_pp_valid;

endmodule
